// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared types and encodings for the I2C transaction sequencer.
// State enum, handshake phase, core command / error encodings and the
// header word field positions live here so every file agrees on them.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_HDR    = 4'd1,
    S_START  = 4'd2,
    S_ADDR   = 4'd3,
    S_WFETCH = 4'd4,
    S_WBYTE  = 4'd5,
    S_RBYTE  = 4'd6,
    S_RPUSH  = 4'd7,
    S_STOP   = 4'd8
  } state_t;

  // Per-command handshake progress inside a command state.
  typedef enum logic [1:0] {
    PH_ISSUE = 2'd0,  // not yet offered (may be stalled)
    PH_HOLD  = 2'd1,  // offered, waiting for CORE_READY
    PH_WAIT  = 2'd2   // accepted, waiting for CORE_DONE
  } phase_t;

  localparam logic [2:0] CMD_IDLE  = 3'd0;
  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;
  localparam logic [2:0] CMD_READ  = 3'd3;
  localparam logic [2:0] CMD_STOP  = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_BADLEN  = 2'd3;

  // Header word: {nostop[16], len[15:8], addr[7:1], rw[0]}
  localparam int HDR_RW_BIT     = 0;
  localparam int HDR_ADDR_LSB   = 1;
  localparam int HDR_ADDR_MSB   = 7;
  localparam int HDR_LEN_LSB    = 8;
  localparam int HDR_LEN_MSB    = 15;
  localparam int HDR_NOSTOP_BIT = 16;

  function automatic logic is_cmd_state(state_t s);
    return (s == S_START) || (s == S_ADDR) || (s == S_WBYTE) ||
           (s == S_RBYTE) || (s == S_STOP);
  endfunction

endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// i2c_txn_sequencer_if: FIFO and byte-core signals between the sequencer
// (master modport) and its environment (slave modport).
interface i2c_txn_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              TX_EMPTY;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_RD;
  logic              RX_FULL;
  logic [DATA_W-1:0] RX_DATA;
  logic              RX_WR;
  logic [2:0]        CORE_CMD;
  logic [7:0]        CORE_BYTE;
  logic              CORE_VALID;
  logic              CORE_READY;
  logic              CORE_DONE;
  logic              CORE_ACK;
  logic [7:0]        CORE_RDATA;

  modport master (
    input  TX_EMPTY, TX_DATA, RX_FULL, CORE_READY, CORE_DONE, CORE_ACK, CORE_RDATA,
    output TX_RD, RX_DATA, RX_WR, CORE_CMD, CORE_BYTE, CORE_VALID
  );

  modport slave (
    output TX_EMPTY, TX_DATA, RX_FULL, CORE_READY, CORE_DONE, CORE_ACK, CORE_RDATA,
    input  TX_RD, RX_DATA, RX_WR, CORE_CMD, CORE_BYTE, CORE_VALID
  );
endinterface

// File: rtl/i2c_seq_timeout.sv
// i2c_seq_timeout: wait-cycle counter. Counts while en is high, clears on
// clr (state change) and flags expiry on the cycle the count reaches limit.
// limit == 0 disables expiry.
module i2c_seq_timeout #(
  parameter int TO_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  logic [TO_W-1:0] cnt_q;

  // Saturating wait counter.
  always_ff @(posedge clk) begin
    if (rst || clr)                cnt_q <= '0;
    else if (en && (cnt_q != '1)) cnt_q <= cnt_q + TO_W'(1);
  end

  // The current cycle is the limit-th waiting cycle.
  always_comb begin
    expired = en && (limit != '0) && (cnt_q == (limit - TO_W'(1)));
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: pulls header/data words from a TX FIFO, drives a byte
// level I2C core (START / WRITE / READ / STOP) and pushes read bytes to an
// RX FIFO. Optional feature macro: I2C_SEQ_REPSTART_EN (header bit16 = no
// stop; the next header then opens with a repeated START).
module i2c_txn_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TO_W   = 14
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [13:0]           CFG,
  input  logic [TO_W-1:0]       TIMEOUT,
  i2c_txn_sequencer_if.master   bus,
  output logic                  BUSY,
  output logic                  ERROR,
  output logic [1:0]            ERR_CODE
);

  state_t      state_q, state_d;
  phase_t      ph_q, ph_d;
  logic [6:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
`ifdef I2C_SEQ_REPSTART_EN
  logic        nostop_q, nostop_d;
  logic        rs_q, rs_d;      // bus still held after a no-stop transaction
`endif

  logic              tx_rd, rx_wr, core_valid;
  logic [2:0]        core_cmd, cmd_sel;
  logic [7:0]        core_byte, byte_sel;
  logic [DATA_W-1:0] rx_data;
  logic              in_cmd, stall, op_done, last, end_data;
  logic              waiting, to_clr, to_expired;

  logic unused_hdr;
  assign unused_hdr = ^{CFG[13:1], bus.TX_DATA[DATA_W-1:HDR_NOSTOP_BIT]};

  assign in_cmd  = is_cmd_state(state_q);
  assign stall   = (state_q == S_RBYTE) && bus.RX_FULL;
  assign op_done = (ph_q == PH_WAIT) && bus.CORE_DONE;
  assign last    = ((bcnt_q + 8'd1) == len_q);
  assign waiting = in_cmd || ((state_q == S_WFETCH) && bus.TX_EMPTY);
  assign to_clr  = (state_d != state_q);

  i2c_seq_timeout #(.TO_W(TO_W)) u_timeout (
    .clk     (PCLK),
    .rst     (PRESET),
    .clr     (to_clr),
    .en      (waiting),
    .limit   (TIMEOUT),
    .expired (to_expired)
  );

  // Next-state, handshake and FIFO strobes.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    len_d    = len_q;
    bcnt_d   = bcnt_q;
    byte_d   = byte_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef I2C_SEQ_REPSTART_EN
    nostop_d = nostop_q;
    rs_d     = rs_q;
`endif
    tx_rd      = 1'b0;
    rx_wr      = 1'b0;
    rx_data    = '0;
    core_valid = 1'b0;
    core_cmd   = CMD_IDLE;
    core_byte  = 8'h00;
    cmd_sel    = CMD_IDLE;
    byte_sel   = 8'h00;
    end_data   = 1'b0;

    case (state_q)
      S_START: cmd_sel = CMD_START;
      S_ADDR:  begin cmd_sel = CMD_WRITE; byte_sel = {addr_q, rw_q}; end
      S_WBYTE: begin cmd_sel = CMD_WRITE; byte_sel = byte_q; end
      S_RBYTE: cmd_sel = CMD_READ;
      S_STOP:  cmd_sel = CMD_STOP;
      default: ;
    endcase

    // Command offer: once offered it is held until accepted.
    if (in_cmd) begin
      case (ph_q)
        PH_ISSUE: if (!stall) begin
          core_valid = 1'b1;
          ph_d       = bus.CORE_READY ? PH_WAIT : PH_HOLD;
        end
        PH_HOLD: begin
          core_valid = 1'b1;
          if (bus.CORE_READY) ph_d = PH_WAIT;
        end
        default: ;
      endcase
    end
    if (core_valid) begin
      core_cmd  = cmd_sel;
      core_byte = byte_sel;
    end

    case (state_q)
      S_IDLE: if (CFG[0] && !bus.TX_EMPTY) state_d = S_HDR;
      S_HDR: begin
        tx_rd  = 1'b1;
        err_d  = ERR_NONE;
        addr_d = bus.TX_DATA[HDR_ADDR_MSB:HDR_ADDR_LSB];
        rw_d   = bus.TX_DATA[HDR_RW_BIT];
        len_d  = bus.TX_DATA[HDR_LEN_MSB:HDR_LEN_LSB];
        bcnt_d = 8'd0;
        if (bus.TX_DATA[HDR_LEN_MSB:HDR_LEN_LSB] == 8'd0) begin
          err_d   = ERR_BADLEN;
          state_d = S_IDLE;
        end else begin
          state_d = S_START;
`ifdef I2C_SEQ_REPSTART_EN
          nostop_d = bus.TX_DATA[HDR_NOSTOP_BIT];
          rs_d     = 1'b0;
`endif
        end
      end
      S_START: if (op_done) state_d = S_ADDR;
      S_ADDR: if (op_done) begin
        if (!bus.CORE_ACK) begin
          err_d   = ERR_NACK;
          state_d = S_STOP;
        end else begin
          state_d = rw_q ? S_RBYTE : S_WFETCH;
        end
      end
      S_WFETCH: if (!bus.TX_EMPTY) begin
        tx_rd   = 1'b1;
        byte_d  = bus.TX_DATA[7:0];
        state_d = S_WBYTE;
      end
      S_WBYTE: if (op_done) begin
        if (!bus.CORE_ACK) begin
          err_d   = ERR_NACK;
          state_d = S_STOP;
        end else begin
          bcnt_d = bcnt_q + 8'd1;
          if (last) end_data = 1'b1;
          else      state_d  = S_WFETCH;
        end
      end
      S_RBYTE: if (op_done) begin
        rdata_d = bus.CORE_RDATA;
        state_d = S_RPUSH;
      end
      S_RPUSH: begin
        rx_wr   = 1'b1;
        rx_data = {{(DATA_W-8){1'b0}}, rdata_q};
        bcnt_d  = bcnt_q + 8'd1;
        if (last) end_data = 1'b1;
        else      state_d  = S_RBYTE;
      end
      S_STOP:  if (op_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // All data moved: close with STOP unless the header asked to keep the bus.
    if (end_data) begin
`ifdef I2C_SEQ_REPSTART_EN
      if (nostop_q) begin
        state_d = S_IDLE;
        rs_d    = 1'b1;
      end else begin
        state_d = S_STOP;
      end
`else
      state_d = S_STOP;
`endif
    end

    // Stuck core or FIFO: abandon the transaction without a STOP.
    if (to_expired) begin
      state_d = S_IDLE;
      err_d   = ERR_TIMEOUT;
`ifdef I2C_SEQ_REPSTART_EN
      rs_d    = 1'b0;
`endif
    end

    if (state_d != state_q) ph_d = PH_ISSUE;
  end

  // State and datapath registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= S_IDLE;
      ph_q     <= PH_ISSUE;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      len_q    <= '0;
      bcnt_q   <= '0;
      byte_q   <= '0;
      rdata_q  <= '0;
      err_q    <= ERR_NONE;
`ifdef I2C_SEQ_REPSTART_EN
      nostop_q <= 1'b0;
      rs_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      len_q    <= len_d;
      bcnt_q   <= bcnt_d;
      byte_q   <= byte_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef I2C_SEQ_REPSTART_EN
      nostop_q <= nostop_d;
      rs_q     <= rs_d;
`endif
    end
  end

  assign bus.TX_RD      = tx_rd;
  assign bus.RX_WR      = rx_wr;
  assign bus.RX_DATA    = rx_data;
  assign bus.CORE_VALID = core_valid;
  assign bus.CORE_CMD   = core_cmd;
  assign bus.CORE_BYTE  = core_byte;
  assign ERR_CODE       = err_q;
  assign ERROR          = (err_q != ERR_NONE);
`ifdef I2C_SEQ_REPSTART_EN
  assign BUSY           = (state_q != S_IDLE) || rs_q;
`else
  assign BUSY           = (state_q != S_IDLE);
`endif

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: FIFO queues plus a byte-core responder around the
// sequencer; directed scenarios and randomized transactions checked against
// a transaction-level expectation of the command stream.
module tb_i2c_txn_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [13:0] CFG = '0;
  logic [13:0] TIMEOUT = '0;
  logic        BUSY, ERROR;
  logic [1:0]  ERR_CODE;

  i2c_txn_sequencer_if #(.DATA_W(32)) bus ();

  i2c_txn_sequencer #(.DATA_W(32), .TO_W(14)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .CFG(CFG), .TIMEOUT(TIMEOUT),
    .bus(bus), .BUSY(BUSY), .ERROR(ERROR), .ERR_CODE(ERR_CODE)
  );

  always #5 PCLK = ~PCLK;

  // environment state
  logic [31:0] txq[$];
  logic [7:0]  rdq[$];
  logic [10:0] cmd_log[$];
  logic [7:0]  rx_log[$];
  int  txrd_cnt, valid_cycles, full_viol, rxhi_bad;
  int  nack_idx = -1, ready_max = 0;
  bit  hold_all, hold_read, rxfull_rand;
  bit  acc_flag, pop_pend, done_act, prev_valid;
  int  done_cnt, ready_wait;
  logic [2:0] acc_cmd;
  int  vec = 0, errs = 0;

  initial begin
    bus.TX_EMPTY = 1'b1; bus.TX_DATA = '0; bus.RX_FULL = 1'b0;
    bus.CORE_READY = 1'b0; bus.CORE_DONE = 1'b0; bus.CORE_ACK = 1'b0; bus.CORE_RDATA = '0;
  end

  // Observe DUT outputs mid-cycle.
  always @(negedge PCLK) begin
    if (PRESET) begin
      acc_flag = 0; pop_pend = 0; prev_valid = 0;
    end else begin
      if (bus.TX_RD) begin pop_pend = 1; txrd_cnt++; end
      if (bus.RX_WR) begin
        rx_log.push_back(bus.RX_DATA[7:0]);
        if (bus.RX_DATA[31:8] != 0) rxhi_bad++;
      end
      if (bus.CORE_VALID && !prev_valid && bus.CORE_CMD == 3'd3 && bus.RX_FULL) full_viol++;
      if (bus.CORE_VALID) valid_cycles++;
      if (bus.CORE_VALID && bus.CORE_READY) begin
        cmd_log.push_back({bus.CORE_CMD, bus.CORE_BYTE});
        acc_flag = 1; acc_cmd = bus.CORE_CMD;
      end
      prev_valid = bus.CORE_VALID;
    end
  end

  // Drive FIFO flags and core responses just after each edge.
  always @(posedge PCLK) begin
    #1;
    if (PRESET) begin
      bus.CORE_READY = 0; bus.CORE_DONE = 0; bus.CORE_ACK = 0; bus.RX_FULL = 0;
      done_act = 0; ready_wait = 0;
    end else begin
      if (pop_pend) begin
        if (txq.size() > 0) void'(txq.pop_front());
        pop_pend = 0;
      end
      bus.CORE_DONE = 0;
      if (done_act) begin
        if (done_cnt == 0) begin
          bus.CORE_DONE = 1; done_act = 0;
        end else done_cnt--;
      end
      if (acc_flag) begin
        bus.CORE_READY = 0; acc_flag = 0; done_act = 1;
        done_cnt = $urandom_range(0, 2);
        bus.CORE_ACK = (nack_idx != cmd_log.size() - 1);
        if (acc_cmd == 3'd3 && rdq.size() > 0) bus.CORE_RDATA = rdq.pop_front();
        ready_wait = $urandom_range(0, ready_max);
      end else if (bus.CORE_VALID && !hold_all && !(hold_read && bus.CORE_CMD == 3'd3)) begin
        if (ready_wait == 0) bus.CORE_READY = 1;
        else ready_wait--;
      end else begin
        bus.CORE_READY = 0;
      end
      bus.RX_FULL = rxfull_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    bus.TX_EMPTY = (txq.size() == 0);
    bus.TX_DATA  = (txq.size() == 0) ? 32'h0 : txq[0];
  end

  task automatic clr_logs();
    cmd_log = {}; rx_log = {};
    txrd_cnt = 0; valid_cycles = 0; full_viol = 0; rxhi_bad = 0;
  endtask

  // Wait for a transaction to start and finish; to=1 if the budget ran out.
  task automatic run_txn(input bit drop_cfg, input int budget, output bit to);
    bit seen = 0;
    to = 1;
    for (int c = 0; c < budget; c++) begin
      @(negedge PCLK);
      if (BUSY) begin
        seen = 1;
        if (drop_cfg) CFG[0] = 1'b0;
      end else if (seen) begin
        to = 0;
        break;
      end
    end
    repeat (3) @(negedge PCLK);
  endtask

  function automatic bit q_eq(input logic [10:0] a[$], input logic [10:0] b[$]);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] !== b[i]) return 0;
    return 1;
  endfunction

  function automatic bit b_eq(input logic [7:0] a[$], input logic [7:0] b[$]);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] !== b[i]) return 0;
    return 1;
  endfunction

  task automatic test_reset();
    PRESET = 1; CFG = 0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    vec++;
    if ({bus.TX_RD, bus.RX_WR, bus.CORE_VALID, BUSY, ERROR, ERR_CODE, bus.CORE_CMD,
         bus.CORE_BYTE, bus.RX_DATA} !== '0) begin
      errs++; $display("FAIL reset_outputs: got busy=%b err=%0d valid=%b cmd=%0d, want all 0",
                       BUSY, ERR_CODE, bus.CORE_VALID, bus.CORE_CMD);
    end
    PRESET = 0;
    @(negedge PCLK);
  endtask

  task automatic test_write();
    logic [10:0] exp[$];
    bit to;
    clr_logs(); nack_idx = -1;
    txq.push_back(32'h0000_02A0); txq.push_back(32'h0000_0011); txq.push_back(32'h0000_0022);
    CFG[0] = 1;
    run_txn(0, 500, to);
    exp = '{ {3'd1, 8'h00}, {3'd2, 8'hA0}, {3'd2, 8'h11}, {3'd2, 8'h22}, {3'd4, 8'h00} };
    vec++; if (to) begin errs++; $display("FAIL write_done: timed out, want completion"); end
    vec++; if (!q_eq(cmd_log, exp)) begin errs++; $display("FAIL write_cmds: got %p want %p", cmd_log, exp); end
    vec++; if (txrd_cnt != 3) begin errs++; $display("FAIL write_txrd: got %0d want 3", txrd_cnt); end
    vec++; if (ERROR !== 1'b0) begin errs++; $display("FAIL write_error: got %b want 0", ERROR); end
  endtask

  task automatic test_read();
    logic [10:0] exp[$];
    logic [7:0]  rexp[$];
    bit to;
    clr_logs(); nack_idx = -1;
    rdq = '{8'h5A, 8'h5B, 8'h5C};
    txq.push_back(32'h0000_03A1);
    CFG[0] = 1;
    run_txn(0, 500, to);
    exp  = '{ {3'd1, 8'h00}, {3'd2, 8'hA1}, {3'd3, 8'h00}, {3'd3, 8'h00}, {3'd3, 8'h00}, {3'd4, 8'h00} };
    rexp = '{8'h5A, 8'h5B, 8'h5C};
    vec++; if (to) begin errs++; $display("FAIL read_done: timed out, want completion"); end
    vec++; if (!q_eq(cmd_log, exp)) begin errs++; $display("FAIL read_cmds: got %p want %p", cmd_log, exp); end
    vec++; if (!b_eq(rx_log, rexp) || rxhi_bad != 0) begin
      errs++; $display("FAIL read_rx: got %p (hi_bad=%0d) want %p", rx_log, rxhi_bad, rexp); end
    vec++; if (txrd_cnt != 1 || ERROR !== 1'b0) begin
      errs++; $display("FAIL read_txrd_err: got txrd=%0d err=%b want 1/0", txrd_cnt, ERROR); end
  endtask

  task automatic test_addr_nack();
    logic [10:0] exp[$];
    bit to;
    clr_logs(); nack_idx = 1;
    txq.push_back(32'h0000_02A0);
    CFG[0] = 1;
    run_txn(0, 500, to);
    exp = '{ {3'd1, 8'h00}, {3'd2, 8'hA0}, {3'd4, 8'h00} };
    vec++; if (to || !q_eq(cmd_log, exp)) begin errs++; $display("FAIL nack_cmds: to=%b got %p want %p", to, cmd_log, exp); end
    vec++; if (ERR_CODE !== 2'd1 || ERROR !== 1'b1) begin
      errs++; $display("FAIL nack_err: got code=%0d error=%b want 1/1", ERR_CODE, ERROR); end
    vec++; if (txrd_cnt != 1) begin errs++; $display("FAIL nack_txrd: got %0d want 1", txrd_cnt); end
    nack_idx = -1;
  endtask

  task automatic test_timeout();
    bit to;
    clr_logs(); hold_all = 1; TIMEOUT = 14'd10;
    txq.push_back(32'h0000_01A1);
    CFG[0] = 1;
    run_txn(0, 200, to);
    vec++; if (to) begin errs++; $display("FAIL timeout_done: timed out, want return to idle"); end
    vec++; if (valid_cycles != 10) begin errs++; $display("FAIL timeout_cycles: got %0d want 10", valid_cycles); end
    vec++; if (ERR_CODE !== 2'd2 || bus.CORE_VALID !== 1'b0 || BUSY !== 1'b0) begin
      errs++; $display("FAIL timeout_state: got code=%0d valid=%b busy=%b want 2/0/0", ERR_CODE, bus.CORE_VALID, BUSY); end
    vec++; if (cmd_log.size() != 0) begin errs++; $display("FAIL timeout_nostop: got %0d accepted cmds want 0", cmd_log.size()); end
    hold_all = 0; TIMEOUT = 0;
  endtask

  task automatic test_badlen();
    bit to;
    clr_logs();
    txq.push_back(32'h0000_00A0);
    CFG[0] = 1;
    run_txn(0, 100, to);
    vec++; if (to || ERR_CODE !== 2'd3 || ERROR !== 1'b1) begin
      errs++; $display("FAIL badlen_err: to=%b got code=%0d error=%b want 3/1", to, ERR_CODE, ERROR); end
    vec++; if (txrd_cnt != 1 || valid_cycles != 0) begin
      errs++; $display("FAIL badlen_traffic: got txrd=%0d valid_cycles=%0d want 1/0", txrd_cnt, valid_cycles); end
  endtask

  task automatic test_cfg_off();
    logic [10:0] exp[$];
    bit to;
    clr_logs(); CFG[0] = 0;
    txq.push_back(32'h0000_01A0); txq.push_back(32'h0000_0033);
    repeat (20) @(negedge PCLK);
    vec++; if (txrd_cnt != 0 || BUSY !== 1'b0) begin
      errs++; $display("FAIL cfg_off_idle: got txrd=%0d busy=%b want 0/0", txrd_cnt, BUSY); end
    CFG[0] = 1;
    run_txn(0, 500, to);
    exp = '{ {3'd1, 8'h00}, {3'd2, 8'hA0}, {3'd2, 8'h33}, {3'd4, 8'h00} };
    vec++; if (to || !q_eq(cmd_log, exp) || ERROR !== 1'b0) begin
      errs++; $display("FAIL cfg_on_write: to=%b got %p err=%b want %p err=0", to, cmd_log, ERROR, exp); end
  endtask

  task automatic test_reset_rbyte();
    logic [10:0] exp[$];
    bit hit = 0;
    clr_logs(); hold_read = 1;
    rdq = '{8'h77, 8'h88};
    txq.push_back(32'h0000_02A1);
    CFG[0] = 1;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge PCLK);
      if (bus.CORE_VALID && bus.CORE_CMD == 3'd3) hit = 1;
    end
    vec++; if (!hit) begin errs++; $display("FAIL rst_rbyte_reach: never saw READ offered, want RBYTE"); end
    PRESET = 1;
    @(posedge PCLK); #1;
    vec++;
    if ({bus.TX_RD, bus.RX_WR, bus.CORE_VALID, BUSY, ERROR, ERR_CODE, bus.CORE_CMD,
         bus.CORE_BYTE, bus.RX_DATA} !== '0) begin
      errs++; $display("FAIL rst_rbyte_outputs: got busy=%b valid=%b cmd=%0d rxwr=%b, want all 0",
                       BUSY, bus.CORE_VALID, bus.CORE_CMD, bus.RX_WR);
    end
    @(negedge PCLK);
    PRESET = 0; hold_read = 0; rdq = {};
    repeat (5) @(negedge PCLK);
    exp = '{ {3'd1, 8'h00}, {3'd2, 8'hA1} };
    vec++; if (!q_eq(cmd_log, exp) || BUSY !== 1'b0) begin
      errs++; $display("FAIL rst_rbyte_nostop: got %p busy=%b want %p busy=0", cmd_log, BUSY, exp); end
  endtask

  // Random transactions; CFG[0] is dropped once busy, so leftovers after a
  // NACK are never taken as a header and are flushed between transactions.
  task automatic test_random();
    rxfull_rand = 1;
    for (int t = 0; t < 25; t++) begin
      logic [10:0] exp[$];
      logic [7:0]  rexp[$], d[$];
      logic [6:0]  addr;
      logic [7:0]  len;
      bit          rw, to;
      int          nk, exp_rd;
      logic [1:0]  exp_err;
      clr_logs();
      addr = 7'($urandom); rw = 1'($urandom); len = 8'($urandom_range(1, 4));
      ready_max = $urandom_range(0, 2);
      nk = ($urandom_range(0, 3) == 0) ? (rw ? 1 : $urandom_range(1, 1 + len)) : -1;
      nack_idx = nk;
      txq.push_back({16'h0000, len, addr, rw});
      for (int i = 0; i < len; i++) begin
        logic [31:0] w;
        w = $urandom;
        w[16] = 1'b0;
        d.push_back(w[7:0]);
        if (rw) rdq.push_back(w[7:0]); else txq.push_back(w);
      end
      // expected stream from the transaction rules
      exp.push_back({3'd1, 8'h00});
      exp.push_back({3'd2, addr, rw});
      exp_rd = 1; exp_err = 2'd0;
      if (nk == 1) exp_err = 2'd1;
      else if (rw) begin
        for (int i = 0; i < len; i++) begin exp.push_back({3'd3, 8'h00}); rexp.push_back(d[i]); end
      end else begin
        for (int i = 0; i < len; i++) begin
          exp.push_back({3'd2, d[i]}); exp_rd++;
          if (nk == 2 + i) begin exp_err = 2'd1; break; end
        end
      end
      exp.push_back({3'd4, 8'h00});
      CFG[0] = 1;
      run_txn(1, 2000, to);
      vec++;
      if (to || !q_eq(cmd_log, exp) || !b_eq(rx_log, rexp) || txrd_cnt != exp_rd ||
          ERR_CODE !== exp_err || full_viol != 0 || rxhi_bad != 0) begin
        errs++;
        $display("FAIL rand_txn%0d: to=%b cmds=%p rx=%p txrd=%0d err=%0d fullv=%0d; want cmds=%p rx=%p txrd=%0d err=%0d",
                 t, to, cmd_log, rx_log, txrd_cnt, ERR_CODE, full_viol, exp, rexp, exp_rd, exp_err);
      end
      txq = {}; rdq = {};
      repeat (2) @(negedge PCLK);
    end
    rxfull_rand = 0; nack_idx = -1; ready_max = 0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_timeout();
    test_badlen();
    test_cfg_off();
    test_reset_rbyte();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
